video_fetcher: RTL and testbench
================================

VIDEO_FETCHER -- requirements
Module: video_fetcher

Interface
REQ-001 SHALL have parameter SRAM_ADDRESS_SIZE, default 9, SRAM word-address width per bank.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, prefetch FIFO entries, power of two, 2..16.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port line_start, input, 1, one-cycle pulse starting a new scanline fetch.
REQ-006 SHALL have port line_base_address, input, SRAM_ADDRESS_SIZE+4, byte address of first word, sampled on line_start.
REQ-007 SHALL have port words_per_line, input, 8, word count, sampled on line_start; 0 means no fetch.
REQ-008 SHALL have ports video_fetchData (output, 1), video_address (output, SRAM_ADDRESS_SIZE+4) and video_data (input, 32), the video-memory read port.
REQ-009 SHALL have ports pixel_request (input, 1, pop), pixel_data (output, 32, FIFO head), pixel_valid (output, 1, FIFO non-empty).
REQ-010 SHALL have ports underflow (output, 1, one-cycle pulse) and line_done (output, 1, one-cycle pulse).

Function
REQ-011 SHALL implement states IDLE, FETCH, DRAIN.
REQ-012 IDLE + line_start with words_per_line>0: load address/remaining counter, go FETCH; words_per_line=0: stay IDLE, pulse line_done next cycle.
REQ-013 FETCH: assert video_fetchData with video_address when remaining>0 and FIFO count + in-flight < FIFO_DEPTH; video_fetchData registered.
REQ-014 Each issued fetch: address += 4 modulo 2^(SRAM_ADDRESS_SIZE+4) (wrap, no saturation); bits [1:0] of video_address always 0; remaining decrements.
REQ-015 Read latency fixed at 1: video_data captured into FIFO the cycle after video_fetchData high; at most one request in flight.
REQ-016 FETCH -> DRAIN when the last word is issued; DRAIN -> IDLE when FIFO empty and nothing in flight, pulsing line_done that cycle.
REQ-017 pixel_valid = FIFO non-empty; pixel_data = head word, 32'h0 when empty.
REQ-018 pixel_request with pixel_valid pops one word; simultaneous push and pop SHALL keep count unchanged and preserve order.
REQ-019 pixel_request with pixel_valid low: no pop, underflow pulses next cycle.
REQ-020 Credit rule of REQ-013 SHALL make FIFO overflow impossible.
REQ-021 line_start outside IDLE: flush FIFO, discard in-flight return data, reload, enter FETCH (or IDLE per REQ-012) next cycle; no line_done for the aborted line.

Reset
REQ-022 rst low SHALL asynchronously force IDLE, FIFO empty, in-flight clear, video_fetchData=0, video_address=0, pixel_valid=0, pixel_data=0, underflow=0, line_done=0.
REQ-023 Release SHALL be synchronised; first fetch no earlier than second clk edge after release.

Configuration
REQ-024 With VIDEO_FETCHER_UNDERFLOW_COUNT_EN defined: output underflow_count (16 bits) and input underflow_count_clear (1 bit); counter increments per underflow pulse, saturates at 16'hFFFF, clear wins over increment, reset to 0.
REQ-025 Without the macro: neither port exists, no counter logic; all other behaviour identical.

Structure
REQ-026 Shared video package/include SHALL hold SRAM_ADDRESS_SIZE, FSM state encodings and read-latency constant (1).
REQ-027 FIFO SHALL be a sub-module video_fetcher_fifo (push, pop, flush, count, head); fetcher holds FSM, counters, credit logic.

Verification
REQ-028 base=0x0100, words=3, memory model returns address as data, no pops -> fetches at 0x0100,0x0104,0x0108; pixel_valid after fetch+2 cycles; line_done only after 3 pops.
REQ-029 words=8, FIFO_DEPTH=4, no pops -> exactly 4 fetches, then stall; popping one word -> exactly one further fetch.
REQ-030 base=0x1FFC, words=2 -> addresses 0x1FFC then 0x0000.
REQ-031 pixel_request while empty -> pixel_data=0, underflow pulse one cycle, underflow_count=1 (macro on), saturates at 0xFFFF after 65536+ underflows.
REQ-032 line_start mid-FETCH with one request in flight -> FIFO empty next cycle, stale word never visible, new line fetched from new base.
REQ-033 rst low during FETCH -> all outputs zero immediately, no fetch until second edge after release.

Source files
------------

// File: rtl/video_fetcher_pkg.sv
// ---------------------------------------------------------------------------
// video_fetcher_pkg
//   Constants and types shared by the scanline video fetcher and its
//   prefetch FIFO.
//   VF_SRAM_ADDRESS_SIZE : default SRAM word-address width per bank
//   VF_READ_LATENCY      : video-memory read latency in clocks
//   VF_WORD_BYTES        : bytes per fetched word (address stride)
//   vf_state_t           : fetcher FSM state encoding
// ---------------------------------------------------------------------------
package video_fetcher_pkg;

  localparam int VF_SRAM_ADDRESS_SIZE = 9;
  localparam int VF_READ_LATENCY      = 1;
  localparam int VF_WORD_BYTES        = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } vf_state_t;

endpackage

// File: rtl/video_fetcher_fifo.sv
// ---------------------------------------------------------------------------
// video_fetcher_fifo
//   Prefetch FIFO between the video-memory read port and the pixel consumer.
//   Ports:
//     clk, rst_n     : clock and internal async active-low reset
//     flush          : drop all contents (wins over push and pop)
//     push/push_data : write one word
//     pop            : remove head word (ignored when empty)
//     count          : number of stored words (0..DEPTH)
//     head           : oldest word, forced to zero when empty
//   DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module video_fetcher_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);

  // Storage has no reset; visibility is governed purely by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Simultaneous push and pop moves both pointers and leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/video_fetcher.sv
// ---------------------------------------------------------------------------
// video_fetcher
//   Fetches one scanline of 32-bit words from video memory into a prefetch
//   FIFO and hands them to the pixel pipeline on request.
//   Ports:
//     clk, rst               : clock, asynchronous active-low reset
//     line_start             : pulse; loads line_base_address / words_per_line
//     line_base_address      : byte address of the first word of the line
//     words_per_line         : words to fetch (0 = empty line)
//     video_fetchData        : registered read strobe to video memory
//     video_address          : registered read byte address (word aligned)
//     video_data             : read data, valid one cycle after the strobe
//     pixel_request          : pop request from the pixel pipeline
//     pixel_data/pixel_valid : FIFO head word / FIFO non-empty
//     underflow              : pulse after a request made while empty
//     line_done              : pulse when a line has been completely consumed
//   Optional (macro VIDEO_FETCHER_UNDERFLOW_COUNT_EN):
//     underflow_count        : saturating count of underflow pulses
//     underflow_count_clear  : synchronous clear, wins over increment
// ---------------------------------------------------------------------------
module video_fetcher
  import video_fetcher_pkg::*;
#(
  parameter int SRAM_ADDRESS_SIZE = VF_SRAM_ADDRESS_SIZE,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         line_start,
  input  logic [SRAM_ADDRESS_SIZE+3:0] line_base_address,
  input  logic [7:0]                   words_per_line,
  output logic                         video_fetchData,
  output logic [SRAM_ADDRESS_SIZE+3:0] video_address,
  input  logic [31:0]                  video_data,
  input  logic                         pixel_request,
  output logic [31:0]                  pixel_data,
  output logic                         pixel_valid,
  output logic                         underflow,
  output logic                         line_done
`ifdef VIDEO_FETCHER_UNDERFLOW_COUNT_EN
  ,
  output logic [15:0]                  underflow_count,
  input  logic                         underflow_count_clear
`endif
);

  localparam int AW = SRAM_ADDRESS_SIZE + 4;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_LIMIT = CW'(FIFO_DEPTH);
  localparam int L = VF_READ_LATENCY;

  vf_state_t         state;
  vf_state_t         state_next;
  logic [1:0]        rst_sync;
  logic              rst_n;
  logic [AW-1:0]     addr;
  logic [7:0]        remaining;
  // Bit 0 is the cycle the strobe is visible, bit L the cycle data returns.
  logic [L:0]        req_pipe;
  logic              in_flight;
  logic              issue;
  logic              drain_done;
  logic              line_done_set;
  logic              underflow_set;
  logic              fifo_pop;
  logic [CW-1:0]     fifo_count;
  logic [31:0]       fifo_head;

  // Assertion is immediate; release passes through two flops so internal
  // state leaves reset only on the second edge after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end
  assign rst_n = rst_sync[1];

  assign in_flight     = |req_pipe;
  assign underflow_set = pixel_request && !pixel_valid;
  assign fifo_pop      = pixel_request && pixel_valid;
  // A new line (even mid-fetch) reports completion only if it is empty.
  assign line_done_set = line_start ? (words_per_line == 8'd0) : drain_done;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state; line_start restarts from any state.
  always_comb begin
    state_next = state;
    if (line_start) begin
      state_next = (words_per_line != 8'd0) ? ST_FETCH : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_next = ST_IDLE;
        ST_FETCH: if (issue && (remaining == 8'd1)) state_next = ST_DRAIN;
        ST_DRAIN: if (drain_done) state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // FSM outputs. Only one read may be outstanding, so the credit check
  // reduces to "FIFO has room and nothing in flight", which rules out overflow.
  always_comb begin
    issue      = 1'b0;
    drain_done = 1'b0;
    case (state)
      ST_FETCH: issue = !line_start && (remaining != 8'd0) && !in_flight &&
                        (fifo_count < DEPTH_LIMIT);
      ST_DRAIN: drain_done = !line_start && (fifo_count == '0) && !in_flight;
      default: begin
        issue      = 1'b0;
        drain_done = 1'b0;
      end
    endcase
  end

  // Address/word counters, request pipeline and status pulses. line_start
  // kills any returning read so stale data never reaches the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr          <= '0;
      remaining     <= '0;
      req_pipe      <= '0;
      video_address <= '0;
      underflow     <= 1'b0;
      line_done     <= 1'b0;
    end else begin
      underflow <= underflow_set;
      line_done <= line_done_set;
      req_pipe  <= {req_pipe[L-1:0] & {L{~line_start}}, issue};
      if (line_start) begin
        addr      <= line_base_address & ~AW'(VF_WORD_BYTES - 1);
        remaining <= words_per_line;
      end else if (issue) begin
        video_address <= addr;
        addr          <= addr + AW'(VF_WORD_BYTES);
        remaining     <= remaining - 8'd1;
      end
    end
  end

  assign video_fetchData = req_pipe[0];

  video_fetcher_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (line_start),
    .push      (req_pipe[L]),
    .push_data (video_data),
    .pop       (fifo_pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign pixel_valid = (fifo_count != '0);
  assign pixel_data  = fifo_head;

`ifdef VIDEO_FETCHER_UNDERFLOW_COUNT_EN
  // Counts each underflow pulse as it is raised; sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_count <= 16'h0000;
    end else if (underflow_count_clear) begin
      underflow_count <= 16'h0000;
    end else if (underflow_set && (underflow_count != 16'hFFFF)) begin
      underflow_count <= underflow_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_video_fetcher.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_video_fetcher
//   Self-checking bench for video_fetcher. A memory model answers each read
//   with {tag, address}; expected words are derived from base + 4*i.
// ---------------------------------------------------------------------------
module tb_video_fetcher;

  localparam int SAS   = 9;
  localparam int AW    = SAS + 4;
  localparam int TW    = 32 - AW;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          line_start;
  logic [AW-1:0] line_base_address;
  logic [7:0]    words_per_line;
  logic          video_fetchData;
  logic [AW-1:0] video_address;
  logic [31:0]   video_data;
  logic          pixel_request;
  logic [31:0]   pixel_data;
  logic          pixel_valid;
  logic          underflow;
  logic          line_done;
`ifdef VIDEO_FETCHER_UNDERFLOW_COUNT_EN
  logic [15:0]   underflow_count;
  logic          underflow_count_clear;
`endif

  int            errors = 0;
  int            checks = 0;
  int            ld_count = 0;
  int            cycle = 0;
  logic [TW-1:0] mem_tag = '0;
  logic [AW-1:0] fetch_log[$];
  logic [31:0]   popped[$];

  always #5 clk = ~clk;

  video_fetcher #(
    .SRAM_ADDRESS_SIZE (SAS),
    .FIFO_DEPTH        (DEPTH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .line_start        (line_start),
    .line_base_address (line_base_address),
    .words_per_line    (words_per_line),
    .video_fetchData   (video_fetchData),
    .video_address     (video_address),
    .video_data        (video_data),
    .pixel_request     (pixel_request),
    .pixel_data        (pixel_data),
    .pixel_valid       (pixel_valid),
    .underflow         (underflow),
    .line_done         (line_done)
`ifdef VIDEO_FETCHER_UNDERFLOW_COUNT_EN
    ,
    .underflow_count       (underflow_count),
    .underflow_count_clear (underflow_count_clear)
`endif
  );

  // Video memory: one-cycle read latency, data = {tag, address}, noise otherwise.
  always @(posedge clk) begin
    video_data <= video_fetchData ? {mem_tag, video_address} : $urandom;
  end

  // Monitor sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    cycle++;
    if (video_fetchData === 1'b1) fetch_log.push_back(video_address);
    if (line_done === 1'b1) ld_count++;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] base, input int i);
    return AW'({base[AW-1:2], 2'b00} + 4 * i);
  endfunction

  function automatic logic [AW-1:0] rand_base();
    logic [AW-1:0] b;
    b = AW'($urandom);
    b[1:0] = 2'b00;
    return b;
  endfunction

  task automatic start_line(input logic [AW-1:0] base, input logic [7:0] words);
    @(negedge clk);
    line_start = 1'b1;
    line_base_address = base;
    words_per_line = words;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  // Pops (with given probability) until a line_done pulse; collects words.
  task automatic drain_line(input int max_cycles, input int pop_pct, output bit timed_out);
    int start_ld;
    start_ld = ld_count;
    timed_out = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      if (ld_count != start_ld) begin
        timed_out = 1'b0;
        break;
      end
      if (pixel_valid && ($urandom_range(99) < pop_pct)) begin
        popped.push_back(pixel_data);
        pixel_request = 1'b1;
      end else begin
        pixel_request = 1'b0;
      end
    end
    pixel_request = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    line_start = 1'b0;
    line_base_address = '0;
    words_per_line = '0;
    pixel_request = 1'b0;
`ifdef VIDEO_FETCHER_UNDERFLOW_COUNT_EN
    underflow_count_clear = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++; if (video_fetchData !== 1'b0) begin errors++; $display("[TB] FAIL reset_fetch: got %b want 0", video_fetchData); end
    checks++; if (video_address !== '0) begin errors++; $display("[TB] FAIL reset_address: got %h want 0", video_address); end
    checks++; if (pixel_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", pixel_valid); end
    checks++; if (pixel_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h want 0", pixel_data); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_underflow: got %b want 0", underflow); end
    checks++; if (line_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_line_done: got %b want 0", line_done); end
`ifdef VIDEO_FETCHER_UNDERFLOW_COUNT_EN
    checks++; if (underflow_count !== 16'h0) begin errors++; $display("[TB] FAIL reset_ucount: got %h want 0", underflow_count); end
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (pixel_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_release_valid: got %b want 0", pixel_valid); end
  endtask

  task automatic test_basic_line();
    int first_fetch;
    int first_valid;
    int ld0;
    bit to;
    first_fetch = -1;
    first_valid = -1;
    mem_tag = TW'($urandom);
    fetch_log.delete();
    popped.delete();
    ld0 = ld_count;
    start_line(AW'(16'h0100), 8'd3);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (first_fetch < 0 && video_fetchData === 1'b1) first_fetch = cycle;
      if (first_valid < 0 && pixel_valid === 1'b1) first_valid = cycle;
    end
    checks++; if (fetch_log.size() != 3) begin errors++; $display("[TB] FAIL basic_fetch_count: got %0d want 3", fetch_log.size()); end
    for (int i = 0; i < 3 && i < fetch_log.size(); i++) begin
      checks++; if (fetch_log[i] !== AW'(16'h0100 + 4 * i)) begin errors++; $display("[TB] FAIL basic_addr[%0d]: got %h want %h", i, fetch_log[i], AW'(16'h0100 + 4 * i)); end
    end
    checks++; if (first_valid - first_fetch != 2) begin errors++; $display("[TB] FAIL basic_valid_latency: got %0d want 2", first_valid - first_fetch); end
    checks++; if (ld_count != ld0) begin errors++; $display("[TB] FAIL basic_early_done: got %0d pulses want 0", ld_count - ld0); end
    drain_line(40, 100, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL basic_done_timeout: got timeout want line_done"); end
    checks++; if (line_done !== 1'b1) begin errors++; $display("[TB] FAIL basic_done_level: got %b want 1", line_done); end
    checks++; if (popped.size() != 3) begin errors++; $display("[TB] FAIL basic_pop_count: got %0d want 3", popped.size()); end
    for (int i = 0; i < 3 && i < popped.size(); i++) begin
      checks++; if (popped[i] !== {mem_tag, AW'(16'h0100 + 4 * i)}) begin errors++; $display("[TB] FAIL basic_word[%0d]: got %h want %h", i, popped[i], {mem_tag, AW'(16'h0100 + 4 * i)}); end
    end
    @(negedge clk);
    checks++; if (line_done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse: got %b want 0", line_done); end
  endtask

  task automatic test_credit();
    logic [AW-1:0] base;
    bit to;
    base = rand_base();
    mem_tag = TW'($urandom);
    fetch_log.delete();
    popped.delete();
    start_line(base, 8'd8);
    repeat (30) @(negedge clk);
    checks++; if (fetch_log.size() != DEPTH) begin errors++; $display("[TB] FAIL credit_stall: got %0d fetches want %0d", fetch_log.size(), DEPTH); end
    popped.push_back(pixel_data);
    pixel_request = 1'b1;
    @(negedge clk);
    pixel_request = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (fetch_log.size() != DEPTH + 1) begin errors++; $display("[TB] FAIL credit_one_more: got %0d fetches want %0d", fetch_log.size(), DEPTH + 1); end
    drain_line(300, 60, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL credit_done_timeout: got timeout want line_done"); end
    checks++; if (popped.size() != 8) begin errors++; $display("[TB] FAIL credit_pop_count: got %0d want 8", popped.size()); end
    for (int i = 0; i < 8 && i < popped.size(); i++) begin
      checks++; if (popped[i] !== {mem_tag, model_addr(base, i)}) begin errors++; $display("[TB] FAIL credit_word[%0d]: got %h want %h", i, popped[i], {mem_tag, model_addr(base, i)}); end
    end
  endtask

  task automatic test_wrap();
    bit to;
    mem_tag = TW'($urandom);
    fetch_log.delete();
    popped.delete();
    start_line(AW'(16'h1FFC), 8'd2);
    drain_line(60, 100, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL wrap_done_timeout: got timeout want line_done"); end
    checks++; if (fetch_log.size() != 2) begin errors++; $display("[TB] FAIL wrap_fetch_count: got %0d want 2", fetch_log.size()); end
    if (fetch_log.size() == 2) begin
      checks++; if (fetch_log[0] !== AW'(16'h1FFC)) begin errors++; $display("[TB] FAIL wrap_addr0: got %h want 1ffc", fetch_log[0]); end
      checks++; if (fetch_log[1] !== AW'(16'h0000)) begin errors++; $display("[TB] FAIL wrap_addr1: got %h want 0000", fetch_log[1]); end
    end
    checks++; if (popped.size() != 2 || popped[1] !== {mem_tag, AW'(0)}) begin errors++; $display("[TB] FAIL wrap_word1: got %0d words want second word %h", popped.size(), {mem_tag, AW'(0)}); end
  endtask

  task automatic test_zero_words();
    int ld0;
    ld0 = ld_count;
    fetch_log.delete();
    start_line(rand_base(), 8'd0);
    checks++; if (line_done !== 1'b1) begin errors++; $display("[TB] FAIL zero_done: got %b want 1", line_done); end
    @(negedge clk);
    checks++; if (line_done !== 1'b0) begin errors++; $display("[TB] FAIL zero_done_pulse: got %b want 0", line_done); end
    repeat (6) @(negedge clk);
    checks++; if (fetch_log.size() != 0 || ld_count != ld0 + 1) begin errors++; $display("[TB] FAIL zero_no_fetch: got %0d fetches %0d pulses want 0 and 1", fetch_log.size(), ld_count - ld0); end
  endtask

  task automatic test_underflow();
    @(negedge clk);
    checks++; if (pixel_valid !== 1'b0 || pixel_data !== 32'h0) begin errors++; $display("[TB] FAIL uf_empty_head: got valid %b data %h want 0 0", pixel_valid, pixel_data); end
`ifdef VIDEO_FETCHER_UNDERFLOW_COUNT_EN
    underflow_count_clear = 1'b1;
    @(negedge clk);
    underflow_count_clear = 1'b0;
`endif
    pixel_request = 1'b1;
    @(negedge clk);
    pixel_request = 1'b0;
    checks++; if (underflow !== 1'b1) begin errors++; $display("[TB] FAIL uf_pulse: got %b want 1", underflow); end
`ifdef VIDEO_FETCHER_UNDERFLOW_COUNT_EN
    checks++; if (underflow_count !== 16'd1) begin errors++; $display("[TB] FAIL uf_count_one: got %h want 0001", underflow_count); end
`endif
    @(negedge clk);
    checks++; if (underflow !== 1'b0) begin errors++; $display("[TB] FAIL uf_pulse_end: got %b want 0", underflow); end
`ifdef VIDEO_FETCHER_UNDERFLOW_COUNT_EN
    pixel_request = 1'b1;
    repeat (65540) @(negedge clk);
    pixel_request = 1'b0;
    @(negedge clk);
    checks++; if (underflow_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL uf_saturate: got %h want ffff", underflow_count); end
    pixel_request = 1'b1;
    underflow_count_clear = 1'b1;
    @(negedge clk);
    pixel_request = 1'b0;
    underflow_count_clear = 1'b0;
    checks++; if (underflow_count !== 16'h0) begin errors++; $display("[TB] FAIL uf_clear_wins: got %h want 0000", underflow_count); end
`endif
  endtask

  task automatic test_abort();
    logic [AW-1:0] base_a;
    logic [AW-1:0] base_b;
    logic [TW-1:0] tag_a;
    int n;
    int ld0;
    bit found;
    bit to;
    base_a = rand_base();
    base_b = rand_base();
    tag_a = TW'($urandom);
    mem_tag = tag_a;
    n = 0;
    found = 1'b0;
    start_line(base_a, 8'd6);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (video_fetchData === 1'b1) begin
        n++;
        if (n == 2) begin
          found = 1'b1;
          break;
        end
      end
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL abort_setup: got %0d fetches want 2", n); end
    checks++; if (pixel_valid !== 1'b1) begin errors++; $display("[TB] FAIL abort_prefill: got valid %b want 1", pixel_valid); end
    ld0 = ld_count;
    fetch_log.delete();
    popped.delete();
    line_start = 1'b1;
    line_base_address = base_b;
    words_per_line = 8'd3;
    @(negedge clk);
    line_start = 1'b0;
    mem_tag = tag_a ^ TW'(1 + $urandom_range(1000));
    checks++; if (pixel_valid !== 1'b0 || pixel_data !== 32'h0) begin errors++; $display("[TB] FAIL abort_flush: got valid %b data %h want 0 0", pixel_valid, pixel_data); end
    drain_line(80, 70, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL abort_done_timeout: got timeout want line_done"); end
    checks++; if (ld_count != ld0 + 1) begin errors++; $display("[TB] FAIL abort_done_count: got %0d pulses want 1", ld_count - ld0); end
    checks++; if (popped.size() != 3) begin errors++; $display("[TB] FAIL abort_pop_count: got %0d want 3", popped.size()); end
    for (int i = 0; i < 3 && i < popped.size(); i++) begin
      checks++; if (popped[i] !== {mem_tag, model_addr(base_b, i)}) begin errors++; $display("[TB] FAIL abort_word[%0d]: got %h want %h", i, popped[i], {mem_tag, model_addr(base_b, i)}); end
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] base;
    logic [7:0] words;
    int pct;
    bit to;
    for (int l = 0; l < 4; l++) begin
      base = rand_base();
      words = 8'($urandom_range(12, 1));
      pct = $urandom_range(100, 20);
      mem_tag = TW'($urandom);
      fetch_log.delete();
      popped.delete();
      start_line(base, words);
      drain_line(400, pct, to);
      checks++; if (to) begin errors++; $display("[TB] FAIL b2b_timeout[%0d]: got timeout want line_done", l); end
      checks++; if (popped.size() != int'(words) || fetch_log.size() != int'(words)) begin errors++; $display("[TB] FAIL b2b_count[%0d]: got %0d pops %0d fetches want %0d", l, popped.size(), fetch_log.size(), words); end
      for (int i = 0; i < int'(words) && i < popped.size() && i < fetch_log.size(); i++) begin
        checks++; if (popped[i] !== {mem_tag, model_addr(base, i)} || fetch_log[i] !== model_addr(base, i)) begin errors++; $display("[TB] FAIL b2b_word[%0d][%0d]: got %h at %h want %h", l, i, popped[i], fetch_log[i], {mem_tag, model_addr(base, i)}); end
      end
    end
  endtask

  task automatic test_reset_midfetch();
    logic [AW-1:0] base_c;
    bit found;
    bit to;
    found = 1'b0;
    start_line(rand_base(), 8'd8);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (video_fetchData === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL rstmid_setup: got no fetch want fetch"); end
    #2 rst = 1'b0;
    #1;
    checks++; if (video_fetchData !== 1'b0 || video_address !== '0) begin errors++; $display("[TB] FAIL rstmid_fetch: got %b %h want 0 0", video_fetchData, video_address); end
    checks++; if (pixel_valid !== 1'b0 || pixel_data !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_pixel: got %b %h want 0 0", pixel_valid, pixel_data); end
    checks++; if (underflow !== 1'b0 || line_done !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_pulses: got %b %b want 0 0", underflow, line_done); end
    @(negedge clk);
    base_c = rand_base();
    mem_tag = TW'($urandom);
    fetch_log.delete();
    popped.delete();
    rst = 1'b1;
    line_start = 1'b1;
    line_base_address = base_c;
    words_per_line = 8'd2;
    @(negedge clk);
    checks++; if (video_fetchData !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_edge1: got %b want 0", video_fetchData); end
    @(negedge clk);
    checks++; if (video_fetchData !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_edge2: got %b want 0", video_fetchData); end
    @(negedge clk);
    line_start = 1'b0;
    drain_line(60, 100, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL rstmid_done_timeout: got timeout want line_done"); end
    checks++; if (popped.size() != 2 || fetch_log.size() != 2) begin errors++; $display("[TB] FAIL rstmid_count: got %0d pops %0d fetches want 2", popped.size(), fetch_log.size()); end
    for (int i = 0; i < 2 && i < popped.size(); i++) begin
      checks++; if (popped[i] !== {mem_tag, model_addr(base_c, i)}) begin errors++; $display("[TB] FAIL rstmid_word[%0d]: got %h want %h", i, popped[i], {mem_tag, model_addr(base_c, i)}); end
    end
  endtask

  initial begin
    $display("[TB] video_fetcher bench starting");
    test_reset();
    test_basic_line();
    test_credit();
    test_wrap();
    test_zero_words();
    test_underflow();
    test_abort();
    test_back_to_back();
    test_reset_midfetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
